vga_frame_fetch_arbiter: RTL and testbench

- Shares one single-port external SRAM between two requesters: the VGA pixel prefetch path (hard real-time) and a generic pixel writer such as a drawing engine (best effort).
- Streams one frame of 16-bit pixel words, in raster order, into a small prefetch FIFO that the VGA colour path pops once per active pixel.
- Gives the writer every SRAM slot the prefetch path does not need.
- Sits between the VGA controller's pixel request and the SRAM interface.

---
 rtl/vga_fetch_pkg.sv | 14 +
 rtl/vga_prefetch_fifo.sv | 64 ++++++
 rtl/vga_frame_fetch_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vga_frame_fetch_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and default frame geometry for the VGA frame fetch arbiter.
package vga_fetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } fetch_state_e;

  typedef logic [15:0] pixel_t;

  localparam int FRAME_W          = 320;
  localparam int FRAME_H          = 240;
  localparam int FRAME_WORDS_DFLT = FRAME_W * FRAME_H;
endpackage

// File: rtl/vga_prefetch_fifo.sv
// Show-ahead pixel FIFO with flush; head is valid whenever count is non-zero.
module vga_prefetch_fifo
  import vga_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  pixel_t                       push_data,
  input  logic                         pop,
  output pixel_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  pixel_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign do_pop = pop && (count_q != '0);

  // Upstream credit accounting guarantees push never lands on a full FIFO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/vga_frame_fetch_arbiter.sv
// Shares one single-port SRAM between VGA frame prefetch (real time) and a pixel writer.
// Define VGA_FETCH_UNDERFLOW_CNT_EN to add the saturating oUnderflow_count output.
module vga_frame_fetch_arbiter
  import vga_fetch_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int FRAME_WORDS = FRAME_WORDS_DFLT,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOW_WM      = 3,
  parameter int RD_LAT      = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iFrame_start,
  input  logic              iPixel_pop,
  output logic [15:0]       oPixel_data,
  output logic              oUnderflow,
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  output logic [15:0]       oUnderflow_count,
`endif
  input  logic              iWr_req,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [15:0]       iWr_data,
  output logic              oWr_ack,
  output logic [ADDR_W-1:0] oSRAM_addr,
  output logic              oSRAM_we_n,
  output logic [15:0]       oSRAM_wdata,
  input  logic [15:0]       iSRAM_rdata
);
  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam int CNW = $clog2(FRAME_WORDS + 1);

  fetch_state_e      state_q, state_d;
  logic              fetch_en, rd_issue, wr_issue, last_word;
  logic              flush, pop_ok, fifo_empty, push;
  logic [CRW-1:0]    credit_q, credit_d, fifo_count;
  logic [CNW-1:0]    word_cnt_q, word_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              underflow_q, underflow_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              sram_we_n_q, sram_we_n_d;
  pixel_t            sram_wdata_q, sram_wdata_d;
  pixel_t            fifo_head;

  assign flush      = iFrame_start;
  assign fifo_empty = (fifo_count == '0);
  assign pop_ok     = iPixel_pop && !fifo_empty;
  assign push       = tag_q[RD_LAT-1];
  assign last_word  = (word_cnt_q == CNW'(FRAME_WORDS - 1));

  // Reads win below the watermark or when the writer is quiet; credit caps FIFO fill.
  always_comb begin
    rd_issue = !Reset && fetch_en && (credit_q < CRW'(FIFO_DEPTH)) &&
               ((credit_q <= CRW'(LOW_WM)) || !iWr_req);
    wr_issue = !Reset && !rd_issue && iWr_req;
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iFrame_start)                                   state_d = S_FETCH;
    else if (state_q == S_FETCH && rd_issue && last_word) state_d = S_DONE;
  end

  always_comb begin
    fetch_en = (state_q == S_FETCH);
  end

  always_comb begin
    credit_d     = credit_q;
    word_cnt_d   = word_cnt_q;
    rd_pend_d    = rd_issue && !flush;
    tag_d        = '0;
    underflow_d  = underflow_q | (iPixel_pop & fifo_empty);
    sram_addr_d  = sram_addr_q;
    sram_we_n_d  = 1'b1;
    sram_wdata_d = sram_wdata_q;

    // Tag enters the pipe when the address reaches the pins, so data returns RD_LAT later.
    if (!flush) begin
      tag_d[0] = rd_pend_q;
      for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    if (flush) begin
      credit_d    = '0;
      word_cnt_d  = '0;
      underflow_d = 1'b0;
    end else begin
      case ({rd_issue, pop_ok})
        2'b10:   credit_d = credit_q + CRW'(1);
        2'b01:   credit_d = credit_q - CRW'(1);
        default: ;
      endcase
      if (rd_issue) word_cnt_d = word_cnt_q + CNW'(1);
    end

    if (rd_issue) begin
      sram_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_cnt_q);
    end else if (wr_issue) begin
      sram_addr_d  = iWr_addr;
      sram_we_n_d  = 1'b0;
      sram_wdata_d = iWr_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      credit_q     <= '0;
      word_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      tag_q        <= '0;
      underflow_q  <= 1'b0;
      sram_addr_q  <= '0;
      sram_we_n_q  <= 1'b1;
      sram_wdata_q <= '0;
    end else begin
      credit_q     <= credit_d;
      word_cnt_q   <= word_cnt_d;
      rd_pend_q    <= rd_pend_d;
      tag_q        <= tag_d;
      underflow_q  <= underflow_d;
      sram_addr_q  <= sram_addr_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  vga_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .flush     (flush),
    .push      (push),
    .push_data (iSRAM_rdata),
    .pop       (pop_ok),
    .head      (fifo_head),
    .count     (fifo_count)
  );

`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (iPixel_pop && fifo_empty && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) ucnt_q <= '0;
    else       ucnt_q <= ucnt_d;
  end

  assign oUnderflow_count = ucnt_q;
`endif

  assign oPixel_data = fifo_empty ? 16'h0000 : fifo_head;
  assign oUnderflow  = underflow_q;
  assign oWr_ack     = wr_issue;
  assign oSRAM_addr  = sram_addr_q;
  assign oSRAM_we_n  = sram_we_n_q;
  assign oSRAM_wdata = sram_wdata_q;
endmodule

// File: tb/tb_vga_frame_fetch_arbiter.sv
// Randomized bench for vga_frame_fetch_arbiter against a queue-based transaction model.
module tb_vga_frame_fetch_arbiter;
  localparam int AW = 18, FW = 16, BASE = 0, DEPTH = 8, LWM = 3, RL = 2;

  logic          Clock = 1'b0;
  logic          Reset, iFrame_start, iPixel_pop, iWr_req;
  logic [AW-1:0] iWr_addr;
  logic [15:0]   iWr_data, iSRAM_rdata;
  logic [15:0]   oPixel_data, oSRAM_wdata;
  logic          oUnderflow, oWr_ack, oSRAM_we_n;
  logic [AW-1:0] oSRAM_addr;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  logic [15:0]   oUnderflow_count;
`endif

  always #5 Clock = ~Clock;

  vga_frame_fetch_arbiter #(
    .ADDR_W(AW), .FRAME_WORDS(FW), .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH), .LOW_WM(LWM), .RD_LAT(RL)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iFrame_start(iFrame_start), .iPixel_pop(iPixel_pop),
    .oPixel_data(oPixel_data), .oUnderflow(oUnderflow),
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    .oUnderflow_count(oUnderflow_count),
`endif
    .iWr_req(iWr_req), .iWr_addr(iWr_addr), .iWr_data(iWr_data), .oWr_ack(oWr_ack),
    .oSRAM_addr(oSRAM_addr), .oSRAM_we_n(oSRAM_we_n), .oSRAM_wdata(oSRAM_wdata),
    .iSRAM_rdata(iSRAM_rdata)
  );

  // SRAM: returns a seeded pattern of the address that was on the pins RL cycles ago.
  logic [15:0]   seed = 16'h5A3C;
  logic [AW-1:0] hist [RL];
  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    return (a[15:0] * 16'd37) ^ seed;
  endfunction
  always @(posedge Clock) begin
    hist[0] <= oSRAM_addr;
    for (int k = 1; k < RL; k++) hist[k] <= hist[k-1];
  end
  assign iSRAM_rdata = pat(hist[RL-1]);

  // Reference model: FIFO contents and in-flight reads as queues.
  typedef struct { logic [AW-1:0] a; int left; } rd_t;
  logic [15:0] m_fifo [$];
  rd_t         m_fl   [$];
  bit          m_fetch = 0, m_unf = 0;
  int          m_cnt = 0, m_ucnt = 0;

  int            n_cmp = 0, n_bad = 0, cyc = 0;
  bit            e_ack, e_rd, e_unf, a_ack, a_unf;
  logic [15:0]   e_pix, a_pix, e_wdata;
  logic [AW-1:0] e_addr;
  logic          e_we_n;
  int            a_ucnt;

  task automatic tick();
    int credit;
    bit rd, wr;
    rd_t r;
    @(negedge Clock);
    credit = m_fifo.size() + m_fl.size();
    rd = !Reset && m_fetch && credit < DEPTH && (credit <= LWM || !iWr_req);
    wr = !Reset && !rd && iWr_req;
    e_ack = wr; e_rd = rd; e_unf = m_unf;
    e_pix = (m_fifo.size() > 0) ? m_fifo[0] : 16'h0000;
    a_ack = oWr_ack; a_pix = oPixel_data; a_unf = oUnderflow;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    a_ucnt = int'(oUnderflow_count);
`else
    a_ucnt = m_ucnt;
`endif
    @(posedge Clock);
    cyc++;
    if (Reset) begin
      m_fifo.delete(); m_fl.delete();
      m_fetch = 0; m_unf = 0; m_cnt = 0; m_ucnt = 0;
      e_addr = '0; e_we_n = 1'b1; e_wdata = '0;
    end else begin
      if (iPixel_pop && m_fifo.size() == 0) begin
        m_unf = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end else if (iPixel_pop) begin
        void'(m_fifo.pop_front());
      end
      foreach (m_fl[i]) m_fl[i].left--;
      while (m_fl.size() > 0 && m_fl[0].left == 0) begin
        r = m_fl.pop_front();
        m_fifo.push_back(pat(r.a));
      end
      e_we_n = 1'b1;
      if (rd) begin
        e_addr = AW'(BASE + m_cnt);
        m_fl.push_back('{AW'(BASE + m_cnt), RL + 1});
        if (m_cnt == FW - 1) m_fetch = 0;
        m_cnt++;
      end else if (wr) begin
        e_addr = iWr_addr; e_we_n = 1'b0; e_wdata = iWr_data;
      end
      if (iFrame_start) begin
        m_fifo.delete(); m_fl.delete();
        m_cnt = 0; m_unf = 0; m_fetch = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1; iFrame_start = 0; iPixel_pop = 0; iWr_req = 0; iWr_addr = '0; iWr_data = '0;
    tick(); tick();
    n_cmp++; if (oSRAM_addr !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", oSRAM_addr); end
    n_cmp++; if (oSRAM_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n got %b want 1", oSRAM_we_n); end
    n_cmp++; if (oSRAM_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", oSRAM_wdata); end
    Reset = 0;
    tick();
    n_cmp++; if (a_pix !== 16'h0) begin n_bad++; $display("FAIL reset_pix got %h want 0", a_pix); end
    n_cmp++; if (a_unf !== 1'b0) begin n_bad++; $display("FAIL reset_unf got %b want 0", a_unf); end
    n_cmp++; if (a_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", a_ack); end
    n_cmp++; if (a_ucnt != 0) begin n_bad++; $display("FAIL reset_ucnt got %0d want 0", a_ucnt); end
  endtask

  task automatic test_underflow();
    iPixel_pop = 1; tick(); iPixel_pop = 0; tick();
    n_cmp++; if (a_unf !== 1'b1) begin n_bad++; $display("FAIL underflow got %b want 1", a_unf); end
    n_cmp++; if (a_pix !== 16'h0) begin n_bad++; $display("FAIL underflow_pix got %h want 0", a_pix); end
    n_cmp++; if (a_ucnt != 1) begin n_bad++; $display("FAIL underflow_cnt got %0d want 1", a_ucnt); end
  endtask

  task automatic test_write_idle();
    iWr_req = 1; iWr_addr = AW'('h100); iWr_data = 16'hBEEF;
    tick();
    iWr_req = 0;
    n_cmp++; if (a_ack !== 1'b1) begin n_bad++; $display("FAIL idle_ack got %b want 1", a_ack); end
    n_cmp++; if (oSRAM_addr !== AW'('h100)) begin n_bad++; $display("FAIL idle_addr got %h want 100", oSRAM_addr); end
    n_cmp++; if (oSRAM_we_n !== 1'b0) begin n_bad++; $display("FAIL idle_we_n got %b want 0", oSRAM_we_n); end
    n_cmp++; if (oSRAM_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL idle_wdata got %h want beef", oSRAM_wdata); end
  endtask

  task automatic test_fill();
    iFrame_start = 1; tick(); iFrame_start = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++; if (a_unf !== 1'b0) begin n_bad++; $display("FAIL fill_unf_clr got %b want 0", a_unf); end
      end
      n_cmp++;
      if (oSRAM_addr !== AW'(BASE + (i < 8 ? i : 7)) || oSRAM_we_n !== 1'b1) begin
        n_bad++; $display("FAIL fill_rd%0d got addr %h we_n %b want addr %h we_n 1", i, oSRAM_addr, oSRAM_we_n, BASE + (i < 8 ? i : 7));
      end
      n_cmp++; if (a_pix !== e_pix) begin n_bad++; $display("FAIL fill_pix%0d got %h want %h", i, a_pix, e_pix); end
    end
  endtask

  task automatic test_flush_inflight();
    bit reached = 0;
    iFrame_start = 1; tick(); iFrame_start = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      iPixel_pop = (m_fifo.size() == 5 && m_fl.size() == 3);
      tick();
      reached = (m_fifo.size() == 5 && m_fl.size() == 2);
    end
    iPixel_pop = 0;
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL flush_setup got unreached want 5 queued 2 in flight"); end
    iFrame_start = 1; tick(); iFrame_start = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++; if (oSRAM_addr !== AW'(BASE) || oSRAM_we_n !== 1'b1) begin n_bad++; $display("FAIL flush_first_rd got %h want %h", oSRAM_addr, BASE); end
        n_cmp++; if (a_pix !== 16'h0) begin n_bad++; $display("FAIL flush_empty got %h want 0", a_pix); end
      end
      if (i == 5) begin
        n_cmp++; if (a_pix !== pat(AW'(BASE))) begin n_bad++; $display("FAIL flush_head got %h want %h", a_pix, pat(AW'(BASE))); end
      end
      n_cmp++; if (a_pix !== e_pix) begin n_bad++; $display("FAIL flush_pix%0d got %h want %h", i, a_pix, e_pix); end
    end
  endtask

  task automatic test_stream_writer();
    iFrame_start = 1; tick(); iFrame_start = 0;
    iWr_req = 1; iPixel_pop = 1; iWr_addr = AW'($urandom); iWr_data = 16'($urandom);
    for (int i = 0; i < 24; i++) begin
      tick();
      n_cmp++; if (a_ack !== e_ack) begin n_bad++; $display("FAIL stream_ack c%0d got %b want %b", cyc, a_ack, e_ack); end
      n_cmp++; if (oSRAM_addr !== e_addr || oSRAM_we_n !== e_we_n) begin n_bad++; $display("FAIL stream_pins c%0d got %h/%b want %h/%b", cyc, oSRAM_addr, oSRAM_we_n, e_addr, e_we_n); end
      n_cmp++; if (a_pix !== e_pix || a_unf !== e_unf) begin n_bad++; $display("FAIL stream_pix c%0d got %h/%b want %h/%b", cyc, a_pix, a_unf, e_pix, e_unf); end
      if (e_ack) begin iWr_addr = AW'($urandom); iWr_data = 16'($urandom); end
    end
    iWr_req = 0; iPixel_pop = 0;
  endtask

  task automatic test_frame_done();
    int nrd = 0;
    iFrame_start = 1; tick(); iFrame_start = 0;
    iPixel_pop = 1;
    for (int i = 0; i < 200 && m_fetch; i++) begin
      tick();
      if (e_rd) begin
        n_cmp++; if (oSRAM_addr !== AW'(BASE + nrd) || oSRAM_we_n !== 1'b1) begin n_bad++; $display("FAIL done_rd%0d got %h want %h", nrd, oSRAM_addr, BASE + nrd); end
        nrd++;
      end
    end
    n_cmp++; if (nrd != FW || m_fetch) begin n_bad++; $display("FAIL done_reads got %0d want %0d", nrd, FW); end
    iWr_req = 1;
    for (int i = 0; i < 8; i++) begin
      iWr_addr = AW'($urandom); iWr_data = 16'($urandom);
      tick();
      n_cmp++; if (a_ack !== 1'b1 || oSRAM_we_n !== 1'b0 || oSRAM_addr !== iWr_addr || oSRAM_wdata !== iWr_data) begin
        n_bad++; $display("FAIL done_wr%0d got ack %b we_n %b addr %h data %h want 1 0 %h %h", i, a_ack, oSRAM_we_n, oSRAM_addr, oSRAM_wdata, iWr_addr, iWr_data);
      end
    end
    iWr_req = 0; iPixel_pop = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Reset        = (i == 300);
      iFrame_start = (i == 0 || i == 302 || $urandom_range(0, 79) == 0);
      iPixel_pop   = ($urandom_range(0, 3) != 0);
      if (!iWr_req && $urandom_range(0, 1) == 1) begin
        iWr_req = 1; iWr_addr = AW'($urandom); iWr_data = 16'($urandom);
      end
      tick();
      if (e_ack) iWr_req = 0;
      n_cmp++; if (a_ack !== e_ack) begin n_bad++; $display("FAIL rnd_ack c%0d got %b want %b", cyc, a_ack, e_ack); end
      n_cmp++; if (a_pix !== e_pix) begin n_bad++; $display("FAIL rnd_pix c%0d got %h want %h", cyc, a_pix, e_pix); end
      n_cmp++; if (a_unf !== e_unf) begin n_bad++; $display("FAIL rnd_unf c%0d got %b want %b", cyc, a_unf, e_unf); end
      n_cmp++; if (oSRAM_addr !== e_addr || oSRAM_we_n !== e_we_n || oSRAM_wdata !== e_wdata) begin
        n_bad++; $display("FAIL rnd_pins c%0d got %h/%b/%h want %h/%b/%h", cyc, oSRAM_addr, oSRAM_we_n, oSRAM_wdata, e_addr, e_we_n, e_wdata);
      end
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
      n_cmp++; if (int'(oUnderflow_count) != m_ucnt) begin n_bad++; $display("FAIL rnd_ucnt c%0d got %0d want %0d", cyc, oUnderflow_count, m_ucnt); end
`endif
    end
    Reset = 0; iFrame_start = 0; iPixel_pop = 0; iWr_req = 0;
  endtask

  initial begin
    seed = 16'($urandom);
    test_reset();
    test_underflow();
    test_write_idle();
    test_fill();
    test_flush_inflight();
    test_stream_writer();
    test_frame_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
